// File: rtl/score_ram_arbiter.sv
// Round-robin arbiter sharing the single-port score RAM between the score writer (A)
// and the leaderboard scanner (B), with per-requester lock and a contention burst limit.
module score_ram_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          lock_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  input  logic          req_b,
  input  logic          lock_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state;
  logic          last_b;
  logic [CW-1:0] burst_cnt;
  logic          pend_a;
  logic          pend_b;
  logic          acc_a;
  logic          acc_b;
  logic [CW:0]   burst_sum;
  logic [CW-1:0] cnt_sat;
  logic          limit_hit;

  assign acc_a = gnt_a & req_a;
  assign acc_b = gnt_b & req_b;

  // RAM pins follow the granted requester; parked at zero otherwise
  assign ram_rw   = acc_a ? we_a   : (acc_b & we_b);
  assign ram_addr = acc_a ? addr_a : (acc_b ? addr_b : '0);
  assign ram_din  = acc_a ? din_a  : (acc_b ? din_b  : '0);

  // A holder already past the limit (it ran alone) yields as soon as the other requests
  assign burst_sum = {1'b0, burst_cnt} + {{CW{1'b0}}, 1'b1};
  assign limit_hit = burst_sum >= (CW+1)'(MAX_BURST);
  assign cnt_sat   = (burst_cnt == '1) ? burst_cnt : burst_sum[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      last_b    <= 1'b1;
      burst_cnt <= '0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      rdata     <= '0;
    end else begin
      pend_a   <= acc_a & ~we_a;
      pend_b   <= acc_b & ~we_b;
      rvalid_a <= pend_a;
      rvalid_b <= pend_b;
      if (pend_a | pend_b) rdata <= ram_dout;

      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (req_a && (!req_b || last_b)) begin
            state <= GNT_A;
            gnt_a <= 1'b1;
          end else if (req_b) begin
            state <= GNT_B;
            gnt_b <= 1'b1;
          end
        end
        GNT_A: begin
          if (!req_a || (!lock_a && req_b && limit_hit)) begin
            last_b    <= 1'b0;
            burst_cnt <= '0;
            gnt_a     <= 1'b0;
            if (req_b) begin
              state <= GNT_B;
              gnt_b <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            burst_cnt <= cnt_sat;
          end
        end
        GNT_B: begin
          if (!req_b || (!lock_b && req_a && limit_hit)) begin
            last_b    <= 1'b1;
            burst_cnt <= '0;
            gnt_b     <= 1'b0;
            if (req_a) begin
              state <= GNT_A;
              gnt_a <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            burst_cnt <= cnt_sat;
          end
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Self-checking bench for score_ram_arbiter: directed table, corner sequences and
// random traffic against a requester-level reference model plus a behavioural RAM.
module tb_score_ram_arbiter;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 16;
  localparam int          MAXB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 0, lock_a = 0, we_a = 0, req_b = 0, lock_b = 0, we_b = 0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, ram_rw;
  logic [DW-1:0] rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  score_ram_arbiter #(.MAX_BURST(MAXB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] ram_mem [32];
  always @(posedge clk) begin
    if (ram_rw) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  typedef struct {
    logic          req_a, lock_a, we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          req_b, lock_b, we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
  } in_t;

  typedef struct {
    in_t  in;
    logic exp_ga, exp_gb;
  } vec_t;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
    int            edge_n;
  } rd_t;

  // Reference model: owner 0=none 1=A 2=B, shadow memory, queue of outstanding reads
  int            own, last, cnt, edge_n;
  logic [DW-1:0] shadow [32];
  rd_t           rq [$];
  int            n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic in_t idle_in();
    in_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic vec_t mk(logic ra, logic la, logic rb, logic lb, logic ea, logic eb);
    vec_t v;
    v.in = idle_in();
    v.in.req_a = ra; v.in.lock_a = la; v.in.req_b = rb; v.in.lock_b = lb;
    v.exp_ga = ea; v.exp_gb = eb;
    return v;
  endfunction

  task automatic check_regs();
    logic          ev_a, ev_b;
    logic [DW-1:0] ed;
    ev_a = 0; ev_b = 0; ed = '0;
    while (rq.size() > 0 && rq[0].edge_n < edge_n - 2) void'(rq.pop_front());
    if (rq.size() > 0 && rq[0].edge_n == edge_n - 2) begin
      ev_a = (rq[0].who == 1);
      ev_b = (rq[0].who == 2);
      ed   = rq[0].data;
      void'(rq.pop_front());
    end
    check("gnt_a", 32'(gnt_a), 32'(own == 1));
    check("gnt_b", 32'(gnt_b), 32'(own == 2));
    check("rvalid_a", 32'(rvalid_a), 32'(ev_a));
    check("rvalid_b", 32'(rvalid_b), 32'(ev_b));
    if (ev_a || ev_b) check("rdata", 32'(rdata), 32'(ed));
  endtask

  // Called at a falling edge: drive, check RAM pins, advance model, cross one rising edge
  task automatic apply(input in_t v);
    logic          r [3];
    logic          l [3];
    logic          w [3];
    logic [AW-1:0] ad [3];
    logic [DW-1:0] dn [3];
    logic          acc;
    int            y;
    req_a = v.req_a; lock_a = v.lock_a; we_a = v.we_a; addr_a = v.addr_a; din_a = v.din_a;
    req_b = v.req_b; lock_b = v.lock_b; we_b = v.we_b; addr_b = v.addr_b; din_b = v.din_b;
    r[0] = 0; l[0] = 0; w[0] = 0; ad[0] = '0; dn[0] = '0;
    r[1] = v.req_a; l[1] = v.lock_a; w[1] = v.we_a; ad[1] = v.addr_a; dn[1] = v.din_a;
    r[2] = v.req_b; l[2] = v.lock_b; w[2] = v.we_b; ad[2] = v.addr_b; dn[2] = v.din_b;
    #1;
    acc = (own != 0) && r[own];
    check("ram_rw", 32'(ram_rw), acc ? 32'(w[own]) : 32'd0);
    check("ram_addr", 32'(ram_addr), acc ? 32'(ad[own]) : 32'd0);
    check("ram_din", 32'(ram_din), (acc && w[own]) ? 32'(dn[own]) : (acc ? 32'(dn[own]) : 32'd0));
    if (acc) begin
      if (w[own]) shadow[ad[own]] = dn[own];
      else rq.push_back('{own, shadow[ad[own]], edge_n});
    end
    if (own == 0) begin
      if (r[1] && r[2]) own = (last == 1) ? 2 : 1;
      else if (r[1])    own = 1;
      else if (r[2])    own = 2;
      cnt = 0;
    end else begin
      y = 3 - own;
      if (!r[own] || (!l[own] && r[y] && cnt + 1 >= MAXB)) begin
        last = own;
        cnt  = 0;
        own  = r[y] ? y : 0;
      end else begin
        cnt = (cnt + 1 > 31) ? 31 : cnt + 1;
      end
    end
    edge_n++;
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  // Called at a falling edge: reset asserted mid-cycle, released one rising edge later
  task automatic do_reset();
    in_t z;
    z = idle_in();
    req_a = z.req_a; lock_a = 0; we_a = 0; req_b = 0; lock_b = 0; we_b = 0;
    rst = 1'b1;
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
    check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    own  = 0;
    last = 2;
    cnt  = 0;
    rq.delete();
  endtask

  initial begin
    vec_t tbl [10];
    in_t  t;
    logic ga [40];
    logic gb [40];
    int   run_a, run_b, k;

    own = 0; last = 2; cnt = 0; edge_n = 0;
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = DW'($urandom);
      shadow[i]  = ram_mem[i];
    end

    @(negedge clk);
    do_reset();

    // Grant table: tie goes to A, direct hand-off, lock alone never grants
    tbl[0] = mk(0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 1, 0);
    tbl[2] = mk(1, 0, 1, 0, 1, 0);
    tbl[3] = mk(0, 0, 1, 0, 0, 1);
    tbl[4] = mk(1, 0, 1, 0, 0, 1);
    tbl[5] = mk(0, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 0, 1, 0, 0, 1);
    tbl[7] = mk(0, 0, 0, 1, 0, 0);
    tbl[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[9] = mk(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d_gnt_a", i), 32'(gnt_a), 32'(tbl[i].exp_ga));
      check($sformatf("tbl%0d_gnt_b", i), 32'(gnt_b), 32'(tbl[i].exp_gb));
    end

    // Reset landing on the rvalid cycle of an in-flight read
    do_reset();
    t = idle_in(); t.req_a = 1; t.addr_a = 5'd3;
    apply(t);
    apply(t);
    t.req_a = 0;
    apply(t);
    check("midrd_rvalid_before_rst", 32'(rvalid_a), 32'd1);
    do_reset();
    t.req_a = 1;
    apply(t);
    check("midrd_regrant", 32'(gnt_a), 32'd1);

    // Write then read back the same address
    do_reset();
    t = idle_in(); t.req_a = 1; t.we_a = 1; t.addr_a = 5'd5; t.din_a = 16'h0A57;
    apply(t);
    apply(t);
    t.we_a = 0;
    apply(t);
    check("wr_rd_early", 32'(rvalid_a), 32'd0);
    t.req_a = 0;
    apply(t);
    check("wr_rd_rvalid", 32'(rvalid_a), 32'd1);
    check("wr_rd_data", 32'(rdata), 32'h0A57);
    apply(t);
    check("wr_rd_single", 32'(rvalid_a), 32'd0);

    // Both streaming reads: alternating runs of MAX_BURST
    do_reset();
    t = idle_in(); t.req_a = 1; t.req_b = 1;
    for (int i = 0; i < 40; i++) begin
      t.addr_a = AW'($urandom); t.addr_b = AW'($urandom);
      apply(t);
      ga[i] = gnt_a; gb[i] = gnt_b;
    end
    k = 0; run_a = 0; run_b = 0;
    while (k < 40 && !ga[k]) k++;
    while (k < 40 && ga[k]) begin run_a++; k++; end
    while (k < 40 && gb[k]) begin run_b++; k++; end
    check("burst_run_a", 32'(run_a), 32'(MAXB));
    check("burst_run_b", 32'(run_b), 32'(MAXB));

    // Lock holds A past the limit while B waits
    do_reset();
    t = idle_in(); t.req_a = 1; t.lock_a = 1; t.req_b = 1;
    for (int i = 0; i < 22; i++) begin
      t.addr_a = AW'($urandom);
      apply(t);
    end
    check("lock_gnt_b_held_off", 32'(gnt_b), 32'd0);
    t.req_a = 0; t.lock_a = 0;
    apply(t);
    check("lock_handoff", 32'(gnt_b), 32'd1);

    // Idle: pins parked, nothing written
    do_reset();
    repeat (10) apply(idle_in());
    for (int i = 0; i < 32; i++) check($sformatf("idle_mem%0d", i), 32'(ram_mem[i]), 32'(shadow[i]));

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t.req_a  = ($urandom_range(0, 3) != 0);
      t.lock_a = ($urandom_range(0, 15) == 0);
      t.we_a   = ($urandom_range(0, 2) == 0);
      t.addr_a = AW'($urandom);
      t.din_a  = DW'($urandom);
      t.req_b  = ($urandom_range(0, 3) != 0);
      t.lock_b = ($urandom_range(0, 15) == 0);
      t.we_b   = ($urandom_range(0, 5) == 0);
      t.addr_b = AW'($urandom);
      t.din_b  = DW'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      apply(t);
    end
    repeat (3) apply(idle_in());
    for (int i = 0; i < 32; i++) check($sformatf("final_mem%0d", i), 32'(ram_mem[i]), 32'(shadow[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
